ctrl_cmd_sequencer: RTL and testbench

- Parametrised command-packet engine for the controller path. It replaces the hand-forced start_exec / exec_out_len / seq stimulus with synthesizable logic.
- On start, it reads a length-prefixed command image from the out-RAM and prepends a 16-bit sequence number. It then emits one UDP header plus payload to the UDP/MAC stack.
- It waits for a reply carrying the matching sequence number and retransmits on timeout.
- It supports NUM_DEST selectable destination IPs.

---
 rtl/ctrl_cmd_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_ctrl_cmd_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_cmd_sequencer.sv
// rtl/ctrl_cmd_sequencer.sv - command packet sequencer with sequence numbering and retransmit
//
// Purpose: on start, reads a length-prefixed command image from the out-RAM,
// sends one UDP header plus a payload of {seq, image words} to the UDP/MAC
// stack, then waits for a reply carrying the same sequence number. The whole
// packet is retransmitted on timeout, up to MAX_RETRY times.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start, dest_sel               request pulse and destination index (sampled on start)
//   dest_ip_flat                  NUM_DEST packed 32-bit destination IPs
//   busy, done, err               status: busy span, completion pulse, result code
//   seq, retry_cnt, mismatch_cnt  sequence number, retransmissions, unmatched replies
//   ram_addr, ram_rdata           out-RAM read port (1-cycle read latency)
//   tx_udp_hdr_*, tx_ip_dest_ip   UDP header handshake and fields
//   tx_payload_*                  byte-wide payload stream
//   rx_reply_*                    reply strobe, reply sequence, constant ready
module ctrl_cmd_sequencer #(
  parameter int          RAM_ADDR_WIDTH = 10,
  parameter int          NUM_DEST       = 2,
  parameter int          DEST_SEL_WIDTH = 1,
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter int          TIMEOUT_WIDTH  = 17,
  parameter int          MAX_RETRY      = 3,
  parameter logic [15:0] CTRL_UDP_PORT  = 16'h1234,
  parameter logic [15:0] SRC_UDP_PORT   = 16'h3456
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DEST_SEL_WIDTH-1:0] dest_sel,
  input  logic [32*NUM_DEST-1:0]    dest_ip_flat,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                err,
  output logic [15:0]               seq,
  output logic [1:0]                retry_cnt,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  input  logic [15:0]               ram_rdata,
  output logic                      tx_udp_hdr_valid,
  input  logic                      tx_udp_hdr_ready,
  output logic [31:0]               tx_ip_dest_ip,
  output logic [15:0]               tx_udp_dest_port,
  output logic [15:0]               tx_udp_source_port,
  output logic [15:0]               tx_udp_length,
  output logic [7:0]                tx_payload_tdata,
  output logic                      tx_payload_tvalid,
  input  logic                      tx_payload_tready,
  output logic                      tx_payload_tlast,
  input  logic                      rx_reply_valid,
  input  logic [15:0]               rx_reply_seq,
  output logic                      rx_reply_ready,
  output logic [7:0]                mismatch_cnt
);

  localparam logic [15:0]              MAX_LEN      = 16'((1 << RAM_ADDR_WIDTH) - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LEN_RD, S_HDR, S_PAY, S_WAIT, S_FIN} state_t;

  state_t                      state, state_next;
  logic [15:0]                 seq_q, udp_len_q, word_buf;
  logic [1:0]                  retry_q, err_q;
  logic [7:0]                  mis_q;
  logic [TIMEOUT_WIDTH-1:0]    timer;
  logic [RAM_ADDR_WIDTH-1:0]   addr_q, len_q, word_idx;
  logic [31:0]                 dest_ip_q;
  logic                        len_phase, hi_byte;
  logic                        bad_dest, len_bad, last_byte, reply_hit, expire, retry_ok;

  always_comb begin
    state_next = state;
    bad_dest   = 32'(dest_sel) >= NUM_DEST;
    len_bad    = ram_rdata > MAX_LEN;
    last_byte  = !hi_byte && (word_idx == len_q);
    reply_hit  = rx_reply_valid && (rx_reply_seq == seq_q);
    expire     = (timer == TIMEOUT_LAST);
    retry_ok   = 32'(retry_q) < MAX_RETRY;

    busy               = (state != S_IDLE);
    done               = (state == S_FIN);
    tx_udp_hdr_valid   = (state == S_HDR);
    tx_ip_dest_ip      = '0;
    tx_udp_dest_port   = '0;
    tx_udp_source_port = '0;
    tx_udp_length      = '0;
    tx_payload_tvalid  = (state == S_PAY);
    tx_payload_tlast   = (state == S_PAY) && last_byte;
    tx_payload_tdata   = hi_byte ? word_buf[15:8] : word_buf[7:0];

    if (state == S_HDR) begin
      tx_ip_dest_ip      = dest_ip_q;
      tx_udp_dest_port   = CTRL_UDP_PORT;
      tx_udp_source_port = SRC_UDP_PORT;
      tx_udp_length      = udp_len_q;
    end

    case (state)
      S_IDLE:   if (start) state_next = bad_dest ? S_FIN : S_LEN_RD;
      S_LEN_RD: if (len_phase) state_next = len_bad ? S_FIN : S_HDR;
      S_HDR:    if (tx_udp_hdr_ready) state_next = S_PAY;
      S_PAY:    if (tx_payload_tready && last_byte) state_next = S_WAIT;
      S_WAIT: begin
        // A reply matching on the expiry cycle takes priority over the retry.
        if (reply_hit)   state_next = S_FIN;
        else if (expire) state_next = retry_ok ? S_LEN_RD : S_FIN;
      end
      S_FIN:    state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // RAM read data follows ram_addr one cycle later and stays put while the
  // address is held. The address always points one word ahead of word_buf,
  // and each word spends at least two cycles on the stream, so the next word
  // is on ram_rdata by the time the low byte is accepted, whatever tready does.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q     <= '0;
      retry_q   <= '0;
      mis_q     <= '0;
      err_q     <= '0;
      timer     <= '0;
      addr_q    <= '0;
      len_phase <= 1'b0;
      len_q     <= '0;
      udp_len_q <= '0;
      dest_ip_q <= '0;
      word_buf  <= '0;
      hi_byte   <= 1'b0;
      word_idx  <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          if (bad_dest) begin
            err_q <= 2'd3;
          end else begin
            err_q     <= 2'd0;
            seq_q     <= seq_q + 16'd1;
            retry_q   <= 2'd0;
            addr_q    <= '0;
            len_phase <= 1'b0;
            dest_ip_q <= dest_ip_flat[32*dest_sel +: 32];
          end
        end
        S_LEN_RD: begin
          // Phase 0 waits out the RAM latency for word 0 and starts the
          // fetch of word 1; phase 1 consumes the length word.
          if (!len_phase) begin
            len_phase <= 1'b1;
            addr_q    <= RAM_ADDR_WIDTH'(1);
          end else if (len_bad) begin
            err_q <= 2'd2;
          end else begin
            len_q     <= ram_rdata[RAM_ADDR_WIDTH-1:0];
            udp_len_q <= 16'd10 + {ram_rdata[14:0], 1'b0};
            word_buf  <= seq_q;
            hi_byte   <= 1'b1;
            word_idx  <= '0;
          end
        end
        S_PAY: if (tx_payload_tready) begin
          if (hi_byte) begin
            hi_byte <= 1'b0;
          end else if (last_byte) begin
            timer <= '0;
          end else begin
            hi_byte  <= 1'b1;
            word_buf <= ram_rdata;
            word_idx <= word_idx + RAM_ADDR_WIDTH'(1);
            addr_q   <= addr_q + RAM_ADDR_WIDTH'(1);
          end
        end
        S_WAIT: begin
          if (rx_reply_valid && !reply_hit && mis_q != 8'hFF) mis_q <= mis_q + 8'd1;
          if (!reply_hit) begin
            if (expire) begin
              if (retry_ok) begin
                retry_q   <= retry_q + 2'd1;
                addr_q    <= '0;
                len_phase <= 1'b0;
              end else begin
                err_q <= 2'd1;
              end
            end else begin
              timer <= timer + TIMEOUT_WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign err            = err_q;
  assign seq            = seq_q;
  assign retry_cnt      = retry_q;
  assign ram_addr       = addr_q;
  assign mismatch_cnt   = mis_q;
  assign rx_reply_ready = 1'b1;

endmodule

// File: tb/tb_ctrl_cmd_sequencer.sv
// tb/tb_ctrl_cmd_sequencer.sv - self-checking bench for ctrl_cmd_sequencer
module tb_ctrl_cmd_sequencer;
  localparam int AW = 4, ND = 2, SW = 2, TO = 50, MR = 2;
  localparam logic [31:0] IP0 = 32'hC0A8_0001, IP1 = 32'hC0A8_0002;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, busy, done, hdr_valid, hdr_ready, tvalid, tready, tlast;
  logic          rx_valid, rx_ready;
  logic [SW-1:0] dest_sel;
  logic [1:0]    err, retry_cnt;
  logic [15:0]   seq, ram_rdata, dport, sport, udp_len, rx_seq;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ip;
  logic [7:0]    tdata, mis_cnt;

  ctrl_cmd_sequencer #(.RAM_ADDR_WIDTH(AW), .NUM_DEST(ND), .DEST_SEL_WIDTH(SW),
                       .TIMEOUT_CYCLES(TO), .TIMEOUT_WIDTH(6), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst), .start(start), .dest_sel(dest_sel), .dest_ip_flat({IP1, IP0}),
    .busy(busy), .done(done), .err(err), .seq(seq), .retry_cnt(retry_cnt),
    .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .tx_udp_hdr_valid(hdr_valid), .tx_udp_hdr_ready(hdr_ready), .tx_ip_dest_ip(ip),
    .tx_udp_dest_port(dport), .tx_udp_source_port(sport), .tx_udp_length(udp_len),
    .tx_payload_tdata(tdata), .tx_payload_tvalid(tvalid), .tx_payload_tready(tready),
    .tx_payload_tlast(tlast), .rx_reply_valid(rx_valid), .rx_reply_seq(rx_seq),
    .rx_reply_ready(rx_ready), .mismatch_cnt(mis_cnt));

  // out-RAM with one cycle of read latency
  logic [15:0] mem [0:15];
  always @(posedge clk) ram_rdata <= mem[ram_addr];

  int n_cmp = 0, n_bad = 0;
  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  // ---------------- monitor: records handshakes at the negedge ----------------
  logic [7:0]  cap_b[$];
  bit          cap_l[$];
  logic [15:0] cap_len[$];
  logic [31:0] cap_ip[$], cap_port[$];
  int          tl_cnt = 0, stab_viol = 0;
  initial begin
    bit st_p, hs_p, st_l;
    logic [7:0] st_d;
    logic [79:0] hs_f;
    st_p = 0; hs_p = 0; st_l = 0; st_d = 0; hs_f = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        st_p = 0; hs_p = 0;
      end else begin
        if (st_p && (!tvalid || tdata !== st_d || tlast !== st_l)) stab_viol++;
        if (hs_p && (!hdr_valid || {ip, udp_len, dport, sport} !== hs_f)) stab_viol++;
        if (tvalid && tready) begin
          cap_b.push_back(tdata);
          cap_l.push_back(tlast);
          if (tlast) tl_cnt++;
        end
        if (hdr_valid && hdr_ready) begin
          cap_len.push_back(udp_len);
          cap_ip.push_back(ip);
          cap_port.push_back({dport, sport});
        end
        st_p = tvalid && !tready; st_d = tdata; st_l = tlast;
        hs_p = hdr_valid && !hdr_ready; hs_f = {ip, udp_len, dport, sport};
      end
    end
  end

  // ---------------- driver: ready patterns and reply agent ----------------
  int          tmode = 0, hdelay = 0, rep_delay = -1;
  bit          rep_bad = 0, inj_rx = 0;
  logic [15:0] rep_seq = 0, inj_seq = 0;
  initial begin
    int hcnt, w, tl_last;
    bit tog;
    hcnt = 0; w = -1; tl_last = 0; tog = 0;
    tready = 0; hdr_ready = 0; rx_valid = 0; rx_seq = 0;
    forever begin
      @(posedge clk); #1;
      case (tmode)
        0:       tready = 1'b1;
        1:       begin tog = !tog; tready = tog; end
        default: tready = 1'($urandom_range(0, 1));
      endcase
      if (hdr_valid) begin hdr_ready = (hcnt >= hdelay); hcnt++; end
      else begin hdr_ready = 0; hcnt = 0; end
      // w counts WAIT cycles: 0 on the first cycle after the tlast handshake
      if (start) w = -1;
      else if (tl_cnt != tl_last) begin w = 0; tl_last = tl_cnt; end
      else if (w >= 0) w++;
      rx_valid = 0;
      if (w >= 0 && w == rep_delay) begin rx_valid = 1; rx_seq = rep_seq; end
      else if (rep_bad && w >= 0 && w == rep_delay - 5) begin rx_valid = 1; rx_seq = rep_seq + 16'd4; end
      if (inj_rx) begin rx_valid = 1; rx_seq = inj_seq; end
    end
  end

  // ---------------- reference model and command runner ----------------
  typedef struct {
    int len; int sel; int dly; bit bad; int tm; int hd; int hold; int e_err; int e_retry;
  } vec_t;

  logic [15:0] m_seq = 0;
  int          m_retry = 0, m_mis = 0;

  task automatic run_cmd(input vec_t v, input bit fixed_img);
    int np, e, r, h0, b0, sv0, c;
    logic [7:0] exp_b[$];
    bit exp_l[$];
    mem[0] = 16'(v.len);
    for (int k = 1; k < 16; k++) mem[k] = 16'($urandom);
    if (fixed_img) begin mem[1] = 16'hABCD; mem[2] = 16'h1234; end
    // Outcome from the rules: bad dest leaves seq/retry alone; otherwise a new
    // seq, then bad length, a reply inside the TO-cycle window, or MR+1 packets.
    if (v.sel >= ND) begin
      e = 3; np = 0;
    end else begin
      m_seq = m_seq + 16'd1; m_retry = 0;
      if (v.len > 15) begin e = 2; np = 0; end
      else if (v.dly >= 0 && v.dly < TO) begin
        e = 0; np = 1;
        if (v.bad && v.dly >= 5 && m_mis < 255) m_mis++;
      end else begin e = 1; np = MR + 1; m_retry = MR; end
    end
    r = m_retry;
    if (v.e_err >= 0) begin e = v.e_err; r = v.e_retry; end
    for (int p = 0; p < np; p++) begin
      exp_b.push_back(m_seq[15:8]); exp_l.push_back(0);
      exp_b.push_back(m_seq[7:0]);  exp_l.push_back(v.len == 0);
      for (int k = 1; k <= v.len; k++) begin
        exp_b.push_back(mem[k][15:8]); exp_l.push_back(0);
        exp_b.push_back(mem[k][7:0]);  exp_l.push_back(k == v.len);
      end
    end
    tmode = v.tm; hdelay = v.hd; rep_delay = v.dly; rep_bad = v.bad; rep_seq = m_seq;
    h0 = cap_len.size(); b0 = cap_b.size(); sv0 = stab_viol;
    dest_sel = SW'(v.sel); start = 1;
    for (int i = 0; i < v.hold; i++) begin @(posedge clk); #1; end
    start = 0;
    chk("busy_after_start", busy, 1);
    c = 0;
    while (!done && c < 3000) begin @(posedge clk); #1; c++; end
    if (!done) begin chk("done_timeout", 0, 1); return; end
    chk("err", err, 64'(e));
    chk("seq", seq, m_seq);
    chk("retry_cnt", retry_cnt, 64'(r));
    chk("mismatch_cnt", mis_cnt, 64'(m_mis));
    chk("busy_at_done", busy, 1);
    chk("hdr_count", cap_len.size() - h0, 64'(np));
    for (int p = 0; p < np && h0 + p < cap_len.size(); p++) begin
      chk("udp_length", cap_len[h0+p], 64'(10 + 2 * v.len));
      chk("dest_ip", cap_ip[h0+p], (v.sel == 1) ? IP1 : IP0);
      chk("udp_ports", cap_port[h0+p], 32'h1234_3456);
    end
    chk("byte_count", cap_b.size() - b0, exp_b.size());
    if (cap_b.size() - b0 == exp_b.size())
      for (int i = 0; i < exp_b.size(); i++) begin
        chk($sformatf("tdata[%0d]", i), cap_b[b0+i], exp_b[i]);
        chk($sformatf("tlast[%0d]", i), cap_l[b0+i], exp_l[i]);
      end
    chk("stall_stability", stab_viol - sv0, 0);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
    chk("err_held", err, 64'(e));
  endtask

  vec_t tbl[12];
  initial begin
    vec_t v;
    int c;
    #900000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int c;
    //        len  sel dly bad tm hd hold err retry
    tbl[0]  = '{2,  0, 20, 0, 0, 0, 1, 0, 0};
    tbl[1]  = '{2,  0, 20, 0, 1, 5, 1, 0, 0};
    tbl[2]  = '{2,  0, -1, 0, 0, 0, 1, 1, 2};
    tbl[3]  = '{2,  0, 20, 1, 0, 0, 1, 0, 0};
    tbl[4]  = '{0,  0, 10, 0, 0, 0, 1, 0, 0};
    tbl[5]  = '{2,  2, 20, 0, 0, 0, 1, 3, 0};
    tbl[6]  = '{2,  0, 49, 0, 0, 0, 1, 0, 0};
    tbl[7]  = '{2,  0, 50, 0, 0, 0, 1, 1, 2};
    tbl[8]  = '{3,  3, 20, 0, 0, 0, 1, 3, 2};
    tbl[9]  = '{16, 0, 20, 0, 0, 0, 1, 2, 0};
    tbl[10] = '{15, 1, 30, 0, 2, 3, 3, 0, 0};
    tbl[11] = '{1,  1, 5,  1, 1, 0, 1, 0, 0};
    for (int k = 0; k < 16; k++) mem[k] = 16'h0;
    rst = 1; start = 0; dest_sel = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_seq", seq, 0);
    chk("rst_retry", retry_cnt, 0);
    chk("rst_mismatch", mis_cnt, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_hdr_valid", hdr_valid, 0);
    chk("rst_hdr_fields", {ip, dport, sport, udp_len}, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast_tdata", {tlast, tdata}, 0);
    chk("rst_rx_ready", rx_ready, 1);
    rst = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) run_cmd(tbl[i], 1);

    // reply while idle is neither matched nor counted
    inj_seq = 16'h7777; inj_rx = 1;
    @(posedge clk); #1;
    inj_rx = 0;
    repeat (2) begin @(posedge clk); #1; end
    chk("idle_reply_ignored", mis_cnt, 64'(m_mis));
    chk("idle_reply_no_busy", busy, 0);

    // reset in the middle of the payload
    mem[0] = 16'd15; tmode = 0; rep_delay = -1; rep_bad = 0; dest_sel = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
    c = 0;
    while (!tvalid && c < 200) begin @(posedge clk); #1; c++; end
    chk("pay_reached", tvalid, 1);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1;
    @(posedge clk); #1;
    chk("midrst_tvalid", tvalid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_seq", seq, 0);
    rst = 0;
    m_seq = 0; m_retry = 0; m_mis = 0;
    @(posedge clk); #1;
    run_cmd(tbl[0], 1);

    // randomized commands against the model
    for (int i = 0; i < 16; i++) begin
      v.len  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 16'hFFFF)) : int'($urandom_range(0, 15));
      v.sel  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 3)) : int'($urandom_range(0, 1));
      v.dly  = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(5, 49));
      v.bad  = 1'($urandom_range(0, 1));
      v.tm   = int'($urandom_range(0, 2));
      v.hd   = int'($urandom_range(0, 4));
      v.hold = 1; v.e_err = -1; v.e_retry = -1;
      run_cmd(v, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
